// File: rtl/mining_job_loader.sv
// mining_job_loader: collects an 80-byte block header from a byte stream, builds
// the 640-bit header template and target, then runs the start/found/exhausted
// handshake with the miner and returns the outcome on a valid/ready result port.
// Optional feature macro: MINING_JOB_LOADER_NBITS_EN. When defined, the target is
// decoded from the header nBits field (bytes 72..75). When undefined, the target
// is the explicit target_in sampled together with header byte 79.
module mining_job_loader #(
  parameter logic [31:0] DEFAULT_MAX_NONCE = 32'hFFFF_FFFF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         s_valid,
  input  logic [7:0]   s_data,
  input  logic         s_last,
  output logic         s_ready,
  input  logic [31:0]  max_nonce_in,
  input  logic [255:0] target_in,
  output logic         miner_start,
  output logic [639:0] header_template,
  output logic [255:0] target,
  output logic [31:0]  max_nonce,
  input  logic         miner_busy,
  input  logic         miner_found,
  input  logic         miner_exhausted,
  input  logic [31:0]  miner_nonce,
  input  logic [255:0] miner_hash,
  output logic         res_valid,
  input  logic         res_ready,
  output logic         res_found,
  output logic [31:0]  res_nonce,
  output logic [255:0] res_hash,
  output logic         frame_err
);

  typedef enum logic [2:0] {COLLECT, DRAIN, DECODE, MINE, RELEASE, REPORT} state_e;

  state_e         state_q, state_d;
  logic [6:0]     count_q;
  logic [639:0]   header_q;
  logic [255:0]   target_q;
  logic [31:0]    maxNonce_q;
  logic           frameErr_q;
  logic           resFound_q;
  logic [31:0]    resNonce_q;
  logic [255:0]   resHash_q;

  logic           byteFire;
  logic           lastByte;
  logic           minerDone;
  logic [9:0]     wrLsb;

  assign byteFire  = s_valid && s_ready;
  assign lastByte  = (count_q == 7'd79);
  assign minerDone = miner_found || miner_exhausted;
  // Byte k lives at bits [639-8k -: 8], i.e. its LSB sits at 8*(79-k).
  assign wrLsb     = {7'd79 - count_q, 3'b000};

`ifdef MINING_JOB_LOADER_NBITS_EN
  logic           decFirst_q;
  logic           shiftLeft_q;
  logic [4:0]     shiftCnt_q;
  logic [7:0]     nbE;
  logic [23:0]    nbM;
  logic           nbBad;
  logic [4:0]     nbShift;

  // nBits is little-endian in the header: bytes 72..74 mantissa, byte 75 exponent.
  assign nbE     = header_q[39:32];
  assign nbM     = {header_q[47:40], header_q[55:48], header_q[63:56]};
  assign nbBad   = (nbE > 8'd32) || nbM[23];
  assign nbShift = (nbE > 8'd3) ? 5'(nbE - 8'd3) : 5'(8'd3 - nbE);
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= COLLECT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic for the job lifecycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      COLLECT: begin
        if (byteFire && lastByte) begin
          state_d = s_last ? DECODE : DRAIN;
        end
      end
      DRAIN: begin
        if (byteFire && s_last) begin
          state_d = COLLECT;
        end
      end
      DECODE: begin
`ifdef MINING_JOB_LOADER_NBITS_EN
        if (decFirst_q) begin
          if (nbBad) begin
            state_d = COLLECT;
          end else if (nbShift == 5'd0) begin
            state_d = MINE;
          end
        end else if (shiftCnt_q == 5'd1) begin
          state_d = MINE;
        end
`else
        state_d = MINE;
`endif
      end
      MINE: begin
        if (minerDone) begin
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        if (!miner_busy && !minerDone) begin
          state_d = REPORT;
        end
      end
      REPORT: begin
        if (res_ready) begin
          state_d = COLLECT;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  // Handshake outputs decoded straight from the current state.
  always_comb begin
    s_ready     = 1'b0;
    miner_start = 1'b0;
    res_valid   = 1'b0;
    case (state_q)
      COLLECT, DRAIN: s_ready     = 1'b1;
      MINE:           miner_start = 1'b1;
      REPORT:         res_valid   = 1'b1;
      default: ;
    endcase
  end

  // Datapath: header assembly, job capture, target decode and result capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q     <= '0;
      header_q    <= '0;
      target_q    <= '0;
      maxNonce_q  <= '0;
      frameErr_q  <= 1'b0;
      resFound_q  <= 1'b0;
      resNonce_q  <= '0;
      resHash_q   <= '0;
`ifdef MINING_JOB_LOADER_NBITS_EN
      decFirst_q  <= 1'b0;
      shiftLeft_q <= 1'b0;
      shiftCnt_q  <= '0;
`endif
    end else begin
      frameErr_q <= 1'b0;
      case (state_q)
        COLLECT: begin
          if (byteFire) begin
            header_q[wrLsb +: 8] <= s_data;
            if (lastByte) begin
              count_q <= '0;
              if (s_last) begin
                maxNonce_q <= (max_nonce_in == 32'd0) ? DEFAULT_MAX_NONCE : max_nonce_in;
`ifdef MINING_JOB_LOADER_NBITS_EN
                decFirst_q <= 1'b1;
`else
                target_q   <= target_in;
`endif
              end else begin
                frameErr_q <= 1'b1;
              end
            end else if (s_last) begin
              frameErr_q <= 1'b1;
              count_q    <= '0;
            end else begin
              count_q <= count_q + 7'd1;
            end
          end
        end
`ifdef MINING_JOB_LOADER_NBITS_EN
        DECODE: begin
          decFirst_q <= 1'b0;
          if (decFirst_q) begin
            if (nbBad) begin
              frameErr_q <= 1'b1;
            end else begin
              target_q    <= {232'd0, nbM};
              shiftCnt_q  <= nbShift;
              shiftLeft_q <= (nbE > 8'd3);
            end
          end else begin
            target_q   <= shiftLeft_q ? (target_q << 8) : (target_q >> 8);
            shiftCnt_q <= shiftCnt_q - 5'd1;
          end
        end
`endif
        MINE: begin
          if (minerDone) begin
            resFound_q <= miner_found;
            resNonce_q <= miner_found ? miner_nonce : 32'd0;
            resHash_q  <= miner_hash;
          end
        end
        default: ;
      endcase
    end
  end

  assign header_template = header_q;
  assign target          = target_q;
  assign max_nonce       = maxNonce_q;
  assign frame_err       = frameErr_q;
  assign res_found       = resFound_q;
  assign res_nonce       = resNonce_q;
  assign res_hash        = resHash_q;

endmodule
